// File: rtl/sd_spi_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sd_spi_responder                                           |
// | Description : SPI-mode SD card responder. Oversamples the host SPI lines,|
// |               decodes 48-bit command frames, answers with R1/R3/R7 and   |
// |               streams a 512-byte block for CMD17 from a byte memory port.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sd_spi_responder #(
   parameter int          ACMD41_BUSY = 2,
   parameter logic [31:0] OCR         = 32'hC0FF8000
) (
   input  logic        sdr_clk_i,
   input  logic        sdr_rst_i,
   input  logic        sdr_sck_i,
   input  logic        sdr_cs_i,
   input  logic        sdr_mosi_i,
   output logic        sdr_miso_o,
   output logic        sdr_mem_rd_o,
   output logic [31:0] sdr_mem_addr_o,
   input  logic [7:0]  sdr_mem_data_i,
   output logic        sdr_init_done_o,
   output logic [5:0]  sdr_cmd_o
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_CMD  = 3'd1;
   localparam logic [2:0] ST_NCR  = 3'd2;
   localparam logic [2:0] ST_RESP = 3'd3;
   localparam logic [2:0] ST_DTOK = 3'd4;
   localparam logic [2:0] ST_DATA = 3'd5;
   localparam logic [2:0] ST_DCRC = 3'd6;

   localparam logic [15:0] BUSY_COUNT = 16'(ACMD41_BUSY);

   logic [2:0]  state, state_nx;
   logic [2:0]  sck_sync;
   logic [1:0]  cs_sync, mosi_sync;
   logic        cs_active, rx_edge, tx_edge, byte_rx, load_fall;
   logic        start_byte, frame_end, drive;
   logic [2:0]  bit_cnt;
   logic [7:0]  rx_shift, rx_byte, tx_shift, data_byte;
   logic [2:0]  byte_idx;
   logic [5:0]  cmd_idx;
   logic [22:0] arg;          // only the bits that reach the address or echo
   logic        app_flag, ncr_skip, acmd_ready;
   logic [15:0] acmd_cnt;
   logic [39:0] resp_buf, dec_buf;
   logic [2:0]  resp_left, dec_left;
   logic        data_go, dec_go, crc_second, rd_d;
   logic [9:0]  data_cnt;

   // Two-flop synchronizers; sck_sync[2] is the delayed copy for edge detection
   always_ff @(posedge sdr_clk_i or negedge sdr_rst_i) begin
      if (!sdr_rst_i) begin
         sck_sync  <= 3'b000;
         cs_sync   <= 2'b11;
         mosi_sync <= 2'b11;
      end else begin
         sck_sync  <= {sck_sync[1:0], sdr_sck_i};
         cs_sync   <= {cs_sync[0], sdr_cs_i};
         mosi_sync <= {mosi_sync[0], sdr_mosi_i};
      end
   end

   assign cs_active  = ~cs_sync[1];
   assign rx_edge    = cs_active & sck_sync[1] & ~sck_sync[2];
   assign tx_edge    = cs_active & ~sck_sync[1] & sck_sync[2];
   assign rx_byte    = {rx_shift[6:0], mosi_sync[1]};
   assign byte_rx    = rx_edge && (bit_cnt == 3'd7);
   // The fall right after the eighth rise of a byte is the byte boundary
   assign load_fall  = tx_edge && (bit_cnt == 3'd0);
   assign start_byte = byte_rx && (state == ST_IDLE) && (rx_byte[7:6] == 2'b01);
   assign frame_end  = byte_rx && (state == ST_CMD) && (byte_idx == 3'd5);
   assign acmd_ready = (acmd_cnt >= BUSY_COUNT);

   // Receive shifter and bit counter; CS high realigns to a byte boundary
   always_ff @(posedge sdr_clk_i or negedge sdr_rst_i) begin
      if (!sdr_rst_i) begin
         bit_cnt  <= 3'd0;
         rx_shift <= 8'h00;
      end else if (!cs_active) begin
         bit_cnt  <= 3'd0;
         rx_shift <= 8'h00;
      end else if (rx_edge) begin
         bit_cnt  <= bit_cnt + 3'd1;
         rx_shift <= rx_byte;
      end
   end

   // Response decode for the frame just completed
   always_comb begin
      dec_buf  = {(sdr_init_done_o ? 8'h04 : 8'h05), 32'hFFFF_FFFF};
      dec_left = 3'd0;
      dec_go   = 1'b0;
      case (cmd_idx)
         6'd0:  dec_buf[39:32] = 8'h01;
         6'd8: begin
            dec_buf  = {8'h01, 8'h00, 8'h00, 8'h01, arg[7:0]};
            dec_left = 3'd4;
         end
         6'd55: dec_buf[39:32] = sdr_init_done_o ? 8'h00 : 8'h01;
         6'd41: if (app_flag) dec_buf[39:32] = acmd_ready ? 8'h00 : 8'h01;
         6'd58: begin
            dec_buf  = {(sdr_init_done_o ? 8'h00 : 8'h01), OCR};
            dec_left = 3'd4;
         end
         6'd17: if (sdr_init_done_o) begin
            dec_buf[39:32] = 8'h00;
            dec_go         = 1'b1;
         end
         default: ;
      endcase
   end

   // Frame collection and card-level state (init, ACMD41 count, app flag)
   always_ff @(posedge sdr_clk_i or negedge sdr_rst_i) begin
      if (!sdr_rst_i) begin
         byte_idx        <= 3'd0;
         cmd_idx         <= 6'd0;
         arg             <= 23'd0;
         sdr_cmd_o       <= 6'd0;
         app_flag        <= 1'b0;
         acmd_cnt        <= 16'd0;
         sdr_init_done_o <= 1'b0;
         ncr_skip        <= 1'b0;
      end else begin
         // The fall that closes the CRC byte must not count as the NCR byte end
         if (load_fall && (state == ST_NCR)) ncr_skip <= 1'b0;
         if (start_byte) begin
            cmd_idx  <= rx_byte[5:0];
            byte_idx <= 3'd1;
         end else if (byte_rx && (state == ST_CMD)) begin
            byte_idx <= byte_idx + 3'd1;
            if (byte_idx != 3'd5) arg <= {arg[14:0], rx_byte};
         end
         if (frame_end) begin
            sdr_cmd_o <= cmd_idx;
            ncr_skip  <= 1'b1;
            app_flag  <= (cmd_idx == 6'd55);
            if (cmd_idx == 6'd0) begin
               sdr_init_done_o <= 1'b0;
               acmd_cnt        <= 16'd0;
            end
            if ((cmd_idx == 6'd41) && app_flag) begin
               if (acmd_ready) sdr_init_done_o <= 1'b1;
               else            acmd_cnt        <= acmd_cnt + 16'd1;
            end
         end
      end
   end

   // Transmit shifter, response sequencing and block-memory reads
   always_ff @(posedge sdr_clk_i or negedge sdr_rst_i) begin
      if (!sdr_rst_i) begin
         tx_shift       <= 8'hFF;
         resp_buf       <= {40{1'b1}};
         resp_left      <= 3'd0;
         data_go        <= 1'b0;
         data_cnt       <= 10'd0;
         crc_second     <= 1'b0;
         sdr_mem_rd_o   <= 1'b0;
         sdr_mem_addr_o <= 32'd0;
         rd_d           <= 1'b0;
         data_byte      <= 8'h00;
      end else begin
         sdr_mem_rd_o <= 1'b0;
         rd_d         <= sdr_mem_rd_o;
         if (rd_d) data_byte <= sdr_mem_data_i;
         if (!cs_active) begin
            tx_shift <= 8'hFF;
         end else if (frame_end) begin
            resp_buf  <= dec_buf;
            resp_left <= dec_left;
            data_go   <= dec_go;
         end else if (tx_edge) begin
            if (bit_cnt != 3'd0) begin
               tx_shift <= {tx_shift[6:0], 1'b1};
            end else begin
               case (state)
                  ST_NCR: if (!ncr_skip) begin
                     tx_shift <= resp_buf[39:32];
                     resp_buf <= {resp_buf[31:0], 8'hFF};
                  end
                  ST_RESP: begin
                     if (resp_left != 3'd0) begin
                        tx_shift  <= resp_buf[39:32];
                        resp_buf  <= {resp_buf[31:0], 8'hFF};
                        resp_left <= resp_left - 3'd1;
                     end else if (data_go) begin
                        tx_shift       <= 8'hFE;
                        sdr_mem_rd_o   <= 1'b1;
                        sdr_mem_addr_o <= {arg, 9'd0};
                        data_cnt       <= 10'd0;
                     end
                  end
                  ST_DTOK: begin
                     tx_shift       <= data_byte;
                     data_cnt       <= 10'd1;
                     sdr_mem_rd_o   <= 1'b1;
                     sdr_mem_addr_o <= sdr_mem_addr_o + 32'd1;
                  end
                  ST_DATA: begin
                     if (data_cnt == 10'd512) begin
                        tx_shift   <= 8'hFF;
                        crc_second <= 1'b0;
                     end else begin
                        tx_shift <= data_byte;
                        data_cnt <= data_cnt + 10'd1;
                        // No read beyond the last byte of the block
                        if (data_cnt != 10'd511) begin
                           sdr_mem_rd_o   <= 1'b1;
                           sdr_mem_addr_o <= sdr_mem_addr_o + 32'd1;
                        end
                     end
                  end
                  ST_DCRC: begin
                     tx_shift   <= 8'hFF;
                     crc_second <= 1'b1;
                  end
                  default: tx_shift <= 8'hFF;
               endcase
            end
         end
      end
   end

   // State register
   always_ff @(posedge sdr_clk_i or negedge sdr_rst_i) begin
      if (!sdr_rst_i) state <= ST_IDLE;
      else            state <= state_nx;
   end

   // Next-state logic; CS high aborts any transfer
   always_comb begin
      state_nx = state;
      if (!cs_active) begin
         state_nx = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (start_byte) state_nx = ST_CMD;
            ST_CMD:  if (frame_end) state_nx = ST_NCR;
            ST_NCR:  if (load_fall && !ncr_skip) state_nx = ST_RESP;
            ST_RESP: if (load_fall && (resp_left == 3'd0))
                        state_nx = data_go ? ST_DTOK : ST_IDLE;
            ST_DTOK: if (load_fall) state_nx = ST_DATA;
            ST_DATA: if (load_fall && (data_cnt == 10'd512)) state_nx = ST_DCRC;
            ST_DCRC: if (load_fall && crc_second) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   // MISO is only driven while the card is talking
   always_comb begin
      drive = 1'b0;
      case (state)
         ST_RESP, ST_DTOK, ST_DATA, ST_DCRC: drive = 1'b1;
         default: drive = 1'b0;
      endcase
   end

   assign sdr_miso_o = drive ? tx_shift[7] : 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sd_spi_responder                                        |
// | Description : Self-checking bench for sd_spi_responder: host SPI driver, |
// |               byte and address scoreboards, behavioural block memory.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sd_spi_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sck = 1'b0;
   logic        cs = 1'b1;
   logic        mosi = 1'b1;
   logic        miso, mem_rd, init_done;
   logic [31:0] mem_addr;
   logic [7:0]  mem_data = 8'h00;
   logic [5:0]  cmd;

   int          vectors = 0;
   int          miscompares = 0;
   logic [7:0]  exp_q[$];
   logic [31:0] addr_q[$];

   always #5 clk = ~clk;

   sd_spi_responder #(.ACMD41_BUSY(2), .OCR(32'hC0FF8000)) dut (
      .sdr_clk_i       (clk),
      .sdr_rst_i       (rst_n),
      .sdr_sck_i       (sck),
      .sdr_cs_i        (cs),
      .sdr_mosi_i      (mosi),
      .sdr_miso_o      (miso),
      .sdr_mem_rd_o    (mem_rd),
      .sdr_mem_addr_o  (mem_addr),
      .sdr_mem_data_i  (mem_data),
      .sdr_init_done_o (init_done),
      .sdr_cmd_o       (cmd)
   );

   // Block memory whose content is the low byte of the address
   always @(posedge clk) begin
      if (mem_rd) mem_data <= mem_addr[7:0];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Every read strobe must match the next expected address
   always @(negedge clk) begin
      if (rst_n && mem_rd) begin
         if (addr_q.size() == 0) check("rd_unexpected", 32'(mem_rd), 32'd0);
         else                    check("rd_addr", mem_addr, addr_q.pop_front());
      end
   end

   // Mode-0 host byte: 8 sdr_clk per SCK period, MISO sampled at the rise
   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      for (int i = 7; i >= 0; i--) begin
         mosi = tx[i];
         repeat (4) @(negedge clk);
         sck = 1'b1;
         rx[i] = miso;
         repeat (4) @(negedge clk);
         sck = 1'b0;
      end
   endtask

   // Sends one frame plus the NCR byte, then clocks out every queued response byte
   task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg,
                          input logic [7:0] crc, input string tag);
      logic [7:0] frame [6];
      logic [7:0] rx;
      int         nresp;
      nresp = exp_q.size();
      frame[0] = {2'b01, idx};
      frame[1] = arg[31:24];
      frame[2] = arg[23:16];
      frame[3] = arg[15:8];
      frame[4] = arg[7:0];
      frame[5] = crc;
      for (int i = 0; i < 6; i++) begin
         spi_byte(frame[i], rx);
         check({tag, "_idle"}, 32'(rx), 32'hFF);
      end
      spi_byte(8'hFF, rx);
      check({tag, "_ncr"}, 32'(rx), 32'hFF);
      for (int i = 0; i < nresp; i++) begin
         spi_byte(8'hFF, rx);
         check(tag, 32'(rx), 32'(exp_q.pop_front()));
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_miso"}, 32'(miso), 32'd1);
      check({tag, "_rd"}, 32'(mem_rd), 32'd0);
      check({tag, "_addr"}, mem_addr, 32'd0);
      check({tag, "_init"}, 32'(init_done), 32'd0);
      check({tag, "_cmd"}, 32'(cmd), 32'd0);
   endtask

   initial begin
      #1ms;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [7:0] rx;
      repeat (4) @(negedge clk);
      check_reset("por");
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      cs = 1'b0;
      repeat (8) @(negedge clk);

      // Block read before initialisation is refused and issues no reads
      exp_q.push_back(8'h05);
      run_cmd(6'd17, 32'd2, 8'h01, "cmd17_pre");
      check("cmd17_pre_idx", 32'(cmd), 32'd17);

      exp_q.push_back(8'h01);
      run_cmd(6'd0, 32'd0, 8'h95, "cmd0");
      check("cmd0_idx", 32'(cmd), 32'd0);

      exp_q.push_back(8'h01); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      exp_q.push_back(8'h01); exp_q.push_back(8'hAA);
      run_cmd(6'd8, 32'h0000_01AA, 8'h87, "cmd8");

      // Two busy ACMD41 answers, then ready
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(8'h01);
         run_cmd(6'd55, 32'd0, 8'h01, "cmd55_pre");
         exp_q.push_back((k < 2) ? 8'h01 : 8'h00);
         run_cmd(6'd41, 32'h4000_0000, 8'h01, "acmd41");
         check("init_done_acmd", 32'(init_done), (k == 2) ? 32'd1 : 32'd0);
      end

      exp_q.push_back(8'h00); exp_q.push_back(8'hC0); exp_q.push_back(8'hFF);
      exp_q.push_back(8'h80); exp_q.push_back(8'h00);
      run_cmd(6'd58, 32'd0, 8'h01, "cmd58");

      exp_q.push_back(8'h00);
      run_cmd(6'd55, 32'd0, 8'h01, "cmd55_post");
      exp_q.push_back(8'h04);
      run_cmd(6'd2, 32'd0, 8'h01, "cmd2");
      exp_q.push_back(8'h04);
      run_cmd(6'd41, 32'd0, 8'h01, "cmd41_noapp");

      // Full block read at argument 2: addresses 0x400..0x5FF
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFE);
      for (int i = 0; i < 512; i++) begin
         exp_q.push_back(8'(i));
         addr_q.push_back(32'h400 + 32'(i));
      end
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hFF);
      run_cmd(6'd17, 32'd2, 8'h01, "cmd17_data");
      check("cmd17_rd_all", 32'(addr_q.size()), 32'd0);

      // Abort after 100 data bytes: reads for bytes 0..101 are already out
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFE);
      for (int i = 0; i < 100; i++) exp_q.push_back(8'(i));
      for (int i = 0; i < 102; i++) addr_q.push_back(32'h400 + 32'(i));
      run_cmd(6'd17, 32'd2, 8'h01, "cmd17_abort");
      repeat (8) @(negedge clk);
      cs = 1'b1;
      repeat (8) @(negedge clk);
      check("abort_miso", 32'(miso), 32'd1);
      check("abort_rd", 32'(addr_q.size()), 32'd0);
      cs = 1'b0;
      repeat (8) @(negedge clk);

      exp_q.push_back(8'h00); exp_q.push_back(8'hC0); exp_q.push_back(8'hFF);
      exp_q.push_back(8'h80); exp_q.push_back(8'h00);
      run_cmd(6'd58, 32'd0, 8'h01, "cmd58_abort");
      check("abort_init_kept", 32'(init_done), 32'd1);

      // Reset in the middle of a frame
      spi_byte(8'h51, rx);
      spi_byte(8'h00, rx);
      spi_byte(8'h00, rx);
      rst_n = 1'b0;
      #1;
      check_reset("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      cs = 1'b1;
      repeat (8) @(negedge clk);
      cs = 1'b0;
      repeat (8) @(negedge clk);
      exp_q.push_back(8'h05);
      run_cmd(6'd17, 32'd2, 8'h01, "cmd17_rst");
      check("rst_init", 32'(init_done), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
